inperiph: RTL and testbench

//  Input-peripheral conditioner directly upstream of the load/store unit. Synchronises and

---
 rtl/inperiph_if.sv | 13 +
 rtl/inperiph.sv | 111 +++++++++++
 tb/tb_inperiph.sv | 114 +++++++++++
 3 files changed

// File: rtl/inperiph_if.sv
// Input-peripheral bus: raw board pins in, registered sw/btn load words out.
interface inperiph_if #(
  parameter int unsigned NSW  = 18,
  parameter int unsigned NKEY = 4
);
  logic [NSW-1:0]  sw_in;
  logic [NKEY-1:0] key_in;
  logic [31:0]     sw;
  logic [31:0]     btn;

  modport master (output sw_in, output key_in, input sw, input btn);
  modport slave  (input sw_in, input key_in, output sw, output btn);
endinterface

// File: rtl/inperiph.sv
// Input-peripheral conditioner: synchronises and debounces switches and keys,
// counts debounced key presses, and presents registered sw/btn words to the LSU.
module inperiph #(
  parameter int unsigned NSW      = 18,
  parameter int unsigned NKEY     = 4,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DB_TICKS = 10
) (
  input  logic      clk,
  input  logic      rst,
  inperiph_if.slave bus
);
  localparam int unsigned NB = NSW + NKEY;
  localparam int unsigned CW = $clog2(DB_TICKS) + 1;
  localparam int unsigned PW = $clog2(TICK_DIV);

  logic [NSW-1:0]  r_sw_s1, r_sw_s2;
  logic [NKEY-1:0] r_key_s1, r_key_s2;
  logic [PW-1:0]   r_pre;
  logic            w_tick;
  logic [NB-1:0]   w_sync;
  logic [NB-1:0]   r_stable;
  logic [CW-1:0]   r_cnt [NB];
  logic [NKEY-1:0] r_key_prev;
  logic [3:0]      r_press [NKEY];
  logic [31:0]     w_sw, w_btn;
  logic [31:0]     r_sw, r_btn;

  // Two-flop synchronisers; key flops reset to released (pins are active-low).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_key_s1 <= '1;
      r_key_s2 <= '1;
    end else begin
      r_sw_s1  <= bus.sw_in;
      r_sw_s2  <= r_sw_s1;
      r_key_s1 <= bus.key_in;
      r_key_s2 <= r_key_s1;
    end
  end

  // Keys are inverted here so every debounced bit reads 1 = active.
  assign w_sync = {~r_key_s2, r_sw_s2};
  assign w_tick = (r_pre == PW'(TICK_DIV - 1));

  // Shared sample-tick prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + 1'b1;
  end

  // Per-bit debounce: accept a new level after DB_TICKS consecutive differing ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= '0;
      for (int unsigned i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (w_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_cnt[i] == CW'(DB_TICKS - 1)) begin
            r_stable[i] <= w_sync[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Press counters advance one cycle after a debounced key rises; wrap at 16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_prev <= '0;
      for (int unsigned k = 0; k < NKEY; k++) r_press[k] <= '0;
    end else begin
      r_key_prev <= r_stable[NB-1:NSW];
      for (int unsigned k = 0; k < NKEY; k++) begin
        if (r_stable[NSW+k] && !r_key_prev[k]) r_press[k] <= r_press[k] + 4'd1;
      end
    end
  end

  // Assemble the LSU words; unused bits stay zero.
  always_comb begin
    w_sw             = '0;
    w_sw[NSW-1:0]    = r_stable[NSW-1:0];
    w_btn            = '0;
    w_btn[NKEY-1:0]  = r_stable[NB-1:NSW];
    for (int unsigned k = 0; k < NKEY; k++) w_btn[8 + 4*k +: 4] = r_press[k];
  end

  // Registered output copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw  <= '0;
      r_btn <= '0;
    end else begin
      r_sw  <= w_sw;
      r_btn <= w_btn;
    end
  end

  assign bus.sw  = r_sw;
  assign bus.btn = r_btn;
endmodule

// File: tb/tb_inperiph.sv
// Directed bench for inperiph with TICK_DIV=4, DB_TICKS=3, NSW=18, NKEY=4.
module tb_inperiph;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   n;

  inperiph_if #(.NSW(18), .NKEY(4)) bus ();

  inperiph #(.NSW(18), .NKEY(4), .TICK_DIV(4), .DB_TICKS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  initial begin
    // 1. Reset with keys released and switches low.
    rst        = 1'b1;
    bus.key_in = 4'hF;
    bus.sw_in  = '0;
    #2;
    chk("rst_sw_async", bus.sw, 32'h0);
    chk("rst_btn_async", bus.btn, 32'h0);
    step(3);
    chk("rst_sw", bus.sw, 32'h0);
    chk("rst_btn", bus.btn, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("post_rst_sw", bus.sw, 32'h0);
      chk("post_rst_btn", bus.btn, 32'h0);
    end

    // 2. sw_in[0] rises and is held; output must appear in edges 10..15.
    bus.sw_in[0] = 1'b1;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (bus.sw[0] && n == 0) n = i;
    end
    chk("sw0_latency_window", 32'((n >= 10) && (n <= 15)), 32'h1);
    chk("sw0_word", bus.sw, 32'h0000_0001);

    // 3. Six-cycle glitch on sw_in[5] is rejected and its counter clears.
    bus.sw_in[5] = 1'b1;
    step(6);
    bus.sw_in[5] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("glitch_sw", bus.sw, 32'h0000_0001);
    end
    chk("glitch_cnt5", 32'(dut.r_cnt[5]), 32'h0);

    // 4. Three presses of key 0.
    for (int p = 1; p <= 3; p++) begin
      bus.key_in[0] = 1'b0;
      step(40);
      chk("k0_pressed", 32'(bus.btn[0]), 32'h1);
      chk("k0_count", 32'(bus.btn[11:8]), 32'(p));
      bus.key_in[0] = 1'b1;
      step(40);
      chk("k0_released_word", bus.btn, 32'(p) << 8);
    end

    // 5. Seventeen presses of key 2; its counter wraps through 16 back to 1.
    for (int p = 1; p <= 17; p++) begin
      bus.key_in[2] = 1'b0;
      step(40);
      chk("k2_pressed_bit", 32'(bus.btn[2]), 32'h1);
      bus.key_in[2] = 1'b1;
      step(40);
      chk("k2_released_word", bus.btn, 32'h0000_0300 | (32'(p % 16) << 16));
    end
    chk("k2_final_word", bus.btn, 32'h0001_0300);

    // 6. All switches high, reset mid-debounce, then a full debounce after release.
    bus.sw_in = 18'h3FFFF;
    step(7);
    rst = 1'b1;
    #1;
    chk("mid_rst_sw", bus.sw, 32'h0);
    chk("mid_rst_btn", bus.btn, 32'h0);
    step(3);
    chk("mid_rst_sw_held", bus.sw, 32'h0);
    rst = 1'b0;
    step(5);
    chk("after_rst_sw_early", bus.sw, 32'h0);
    chk("after_rst_btn_early", bus.btn, 32'h0);
    step(20);
    chk("after_rst_sw_all", bus.sw, 32'h0003_FFFF);
    chk("after_rst_btn", bus.btn, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
